// File: rtl/sweep_response_capture_if.sv
// Signal bundle between a sweep controller and the bench or sequencer that drives it.
// The controller takes the slave side; whoever drives start and golden takes the master side.
interface sweep_response_capture_if;
    logic        start;
    logic [15:0] golden;
    logic        dut_out;
    logic [3:0]  N;
    logic        busy;
    logic        done;
    logic [15:0] truth_table;
    logic        mismatch;
    logic [4:0]  mismatch_count;
    logic [3:0]  first_fail;

    modport master (
        output start, golden, dut_out,
        input  N, busy, done, truth_table, mismatch, mismatch_count, first_fail
    );

    modport slave (
        input  start, golden, dut_out,
        output N, busy, done, truth_table, mismatch, mismatch_count, first_fail
    );
endinterface

// File: rtl/sweep_response_capture.sv
// Exhaustive 16-vector sweep of a 4-input block: drive each vector, wait for it to settle,
// capture the response and compare it against the golden truth table latched at start.
//
// state   | meaning
// IDLE    | waiting for start; results from the last sweep are held
// SETTLE  | vector on N, counting settle cycles
// CAPTURE | sample dut_out into truth_table[N], compare, advance N
// DONE    | one-cycle done pulse, publish mismatch flag
module sweep_response_capture #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input logic                    CK,
    input logic                    reset,
    sweep_response_capture_if.slave bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETTLE  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    logic [1:0]  state;
    logic [7:0]  settle_cnt;
    logic [15:0] golden_q;
    logic [3:0]  n_q;
    logic [15:0] truth_table_q;
    logic        mismatch_q;
    logic [4:0]  mismatch_count_q;
    logic [3:0]  first_fail_q;

    always_ff @(posedge CK) begin
        if (!reset) begin
            state            <= IDLE;
            settle_cnt       <= 8'd0;
            golden_q         <= 16'd0;
            n_q              <= 4'd0;
            truth_table_q    <= 16'd0;
            mismatch_q       <= 1'b0;
            mismatch_count_q <= 5'd0;
            first_fail_q     <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        golden_q         <= bus.golden;
                        n_q              <= 4'd0;
                        settle_cnt       <= 8'd0;
                        truth_table_q    <= 16'd0;
                        mismatch_q       <= 1'b0;
                        mismatch_count_q <= 5'd0;
                        first_fail_q     <= 4'd0;
                        state            <= SETTLE;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 8'd1;
                    if (settle_cnt == SETTLE_LAST)
                        state <= CAPTURE;
                end
                CAPTURE: begin
                    truth_table_q[n_q] <= bus.dut_out;
                    if (bus.dut_out != golden_q[n_q]) begin
                        mismatch_count_q <= mismatch_count_q + 5'd1;
                        // a zero count means no earlier vector of this sweep has failed
                        if (mismatch_count_q == 5'd0)
                            first_fail_q <= n_q;
                    end
                    if (n_q != 4'd15) begin
                        n_q        <= n_q + 4'd1;
                        settle_cnt <= 8'd0;
                        state      <= SETTLE;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    mismatch_q <= (mismatch_count_q != 5'd0);
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.N              = n_q;
    assign bus.busy           = (state == SETTLE) || (state == CAPTURE);
    assign bus.done           = (state == DONE);
    assign bus.truth_table    = truth_table_q;
    assign bus.mismatch       = mismatch_q;
    assign bus.mismatch_count = mismatch_count_q;
    assign bus.first_fail     = first_fail_q;

endmodule

// File: tb/tb_sweep_response_capture.sv
// Bench for sweep_response_capture: two instances (settle 1 and settle 3) swept against
// behavioural 4-input blocks; expected sweep results are queued at start and popped at done.
module tb_sweep_response_capture;

    typedef struct {
        logic [15:0] tt;
        logic [4:0]  cnt;
        logic [3:0]  ff;
        logic        mm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   mode1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    sweep_response_capture_if bus1();
    sweep_response_capture_if bus3();

    sweep_response_capture #(.SETTLE_CYCLES(1)) dut1 (.CK(clk), .reset(rst_n), .bus(bus1.slave));
    sweep_response_capture #(.SETTLE_CYCLES(3)) dut3 (.CK(clk), .reset(rst_n), .bus(bus3.slave));

    // 0: AND of inputs, 1: AND with output inverted at vector 5, 2: tied high
    function automatic logic model(int mode, logic [3:0] v);
        logic r;
        r = &v;
        if (mode == 1 && v == 4'd5) r = ~r;
        if (mode == 2) r = 1'b1;
        return r;
    endfunction

    function automatic exp_t expect_for(int mode, logic [15:0] g);
        exp_t        e;
        logic [15:0] d;
        for (int i = 0; i < 16; i++) e.tt[i] = model(mode, 4'(i));
        d     = e.tt ^ g;
        e.cnt = 5'($countones(d));
        e.ff  = 4'd0;
        for (int i = 15; i >= 0; i--) if (d[i]) e.ff = 4'(i);
        e.mm  = (e.cnt != 5'd0);
        return e;
    endfunction

    always_comb bus1.dut_out = model(mode1, bus1.N);
    always_comb bus3.dut_out = model(0, bus3.N);

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero1(string tag);
        chk({tag, "_N"},    32'(bus1.N), 0);
        chk({tag, "_busy"}, 32'(bus1.busy), 0);
        chk({tag, "_done"}, 32'(bus1.done), 0);
        chk({tag, "_tt"},   32'(bus1.truth_table), 0);
        chk({tag, "_mm"},   32'(bus1.mismatch), 0);
        chk({tag, "_cnt"},  32'(bus1.mismatch_count), 0);
        chk({tag, "_ff"},   32'(bus1.first_fail), 0);
    endtask

    // Called at the negedge after the accepting edge (cyc0 edges already elapsed).
    task automatic wait_check_done1(int cyc0, int lat);
        int   cyc;
        exp_t e;
        cyc = cyc0;
        while (!bus1.done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_latency", 32'(cyc), 32'(lat));
        chk("N_at_done", 32'(bus1.N), 32'd15);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk("truth_table", 32'(bus1.truth_table), 32'(e.tt));
            chk("mismatch_count", 32'(bus1.mismatch_count), 32'(e.cnt));
            chk("first_fail", 32'(bus1.first_fail), 32'(e.ff));
            @(negedge clk);
            chk("mismatch", 32'(bus1.mismatch), 32'(e.mm));
            chk("done_pulse_width", 32'(bus1.done), 0);
            chk("busy_after_done", 32'(bus1.busy), 0);
        end
    endtask

    task automatic sweep1(int mode, logic [15:0] g);
        mode1       = mode;
        bus1.golden = g;
        bus1.start  = 1'b1;
        sb.push_back(expect_for(mode, g));
        @(posedge clk);
        @(negedge clk);
        bus1.start = 1'b0;
        chk("busy_after_start", 32'(bus1.busy), 1);
        wait_check_done1(0, 32);
    endtask

    initial begin
        exp_t e3;
        rst_n       = 1'b0;
        mode1       = 0;
        bus1.start  = 1'b0;
        bus1.golden = 16'h0000;
        bus3.start  = 1'b0;
        bus3.golden = 16'h8000;
        repeat (3) @(negedge clk);
        check_zero1("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // settle 3: vector timing and result
        bus3.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus3.start = 1'b0;
        for (int j = 0; j < 64; j++) begin
            if (j % 4 == 0 || j % 4 == 3) chk("s3_N_step", 32'(bus3.N), 32'(j / 4));
            if (j == 63) chk("s3_no_early_done", 32'(bus3.done), 0);
            @(negedge clk);
        end
        chk("s3_done_at_64", 32'(bus3.done), 1);
        chk("s3_N_in_done", 32'(bus3.N), 32'd15);
        e3 = expect_for(0, 16'h8000);
        chk("s3_truth_table", 32'(bus3.truth_table), 32'(e3.tt));
        chk("s3_count", 32'(bus3.mismatch_count), 32'(e3.cnt));
        @(negedge clk);

        sweep1(0, 16'h8000);
        sweep1(1, 16'h8000);
        sweep1(2, 16'h0000);
        repeat (5) @(negedge clk);
        chk("hold_tt", 32'(bus1.truth_table), 32'hFFFF);
        chk("hold_cnt", 32'(bus1.mismatch_count), 32'd16);
        chk("hold_mm", 32'(bus1.mismatch), 1);

        // reset mid-sweep, with start asserted alongside it
        mode1       = 2;
        bus1.golden = 16'h0000;
        bus1.start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_abort_busy", 32'(bus1.busy), 1);
        rst_n      = 1'b0;
        bus1.start = 1'b1;
        @(negedge clk);
        check_zero1("abort");
        rst_n      = 1'b1;
        bus1.start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus1.done || bus1.busy) begin
                chk("abort_stays_idle", 32'(bus1.done | bus1.busy), 0);
                break;
            end
            @(negedge clk);
        end
        sweep1(0, 16'h8000);

        // start held high, golden changed mid-sweep
        mode1       = 0;
        bus1.golden = 16'h8000;
        bus1.start  = 1'b1;
        sb.push_back(expect_for(0, 16'h8000));
        @(posedge clk);
        for (int k = 0; k < 10; k++) @(negedge clk);
        bus1.golden = 16'h0000;
        wait_check_done1(9, 32);
        // now in the single IDLE cycle; golden 0000 gets latched next edge
        sb.push_back(expect_for(0, 16'h0000));
        @(negedge clk);
        chk("b2b_restart_busy", 32'(bus1.busy), 1);
        chk("b2b_restart_N", 32'(bus1.N), 0);
        bus1.start = 1'b0;
        wait_check_done1(0, 32);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sweep_response_capture.md
SWEEP_RESPONSE_CAPTURE -- requirements
Module: sweep_response_capture

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning cycles each vector is held before sampling (legal 1..255).
REQ-002 SHALL have port CK  input  1  rising-edge clock; sole clock.
REQ-003 SHALL have port reset  input  1  synchronous active-low reset.
REQ-004 SHALL have port start  input  1  request one exhaustive 16-vector sweep.
REQ-005 SHALL have port golden  input  16  expected DUT response; bit i = expected output for vector value i.
REQ-006 SHALL have port dut_out  input  1  single-bit response of the 4-input DUT under test.
REQ-007 SHALL have port N  output  4  stimulus vector driven to the DUT.
REQ-008 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-010 SHALL have port truth_table  output  16  captured responses; bit i = dut_out sampled for N=i.
REQ-011 SHALL have port mismatch  output  1  sweep result differs from golden.
REQ-012 SHALL have port mismatch_count  output  5  number of differing vectors, 0..16.
REQ-013 SHALL have port first_fail  output  4  lowest vector value that mismatched.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, CAPTURE, DONE; busy = 1 in SETTLE and CAPTURE only.
REQ-015 IDLE: start=1 SHALL latch golden, set N=0, clear settle counter, truth_table, mismatch, mismatch_count, first_fail, go to SETTLE; start=0 stays in IDLE.
REQ-016 SETTLE: counter SHALL increment each cycle; move to CAPTURE when counter reaches SETTLE_CYCLES-1.
REQ-017 CAPTURE (one cycle): SHALL write dut_out into truth_table[N].
REQ-018 CAPTURE: if dut_out != latched golden[N], SHALL increment mismatch_count; if this is the first mismatch of the sweep, SHALL load first_fail=N.
REQ-019 CAPTURE with N!=15 SHALL set N=N+1, clear counter, go to SETTLE; with N=15 SHALL go to DONE with N held at 15 (no wrap).
REQ-020 DONE: done=1 for exactly that cycle; mismatch SHALL be set to (mismatch_count!=0) including the final vector; next state IDLE unconditionally.
REQ-021 Each vector SHALL be held on N for exactly SETTLE_CYCLES+1 cycles; done SHALL assert 16*(SETTLE_CYCLES+1) cycles after the edge that accepts start.
REQ-022 start SHALL be ignored in SETTLE, CAPTURE and DONE; held-high start yields back-to-back sweeps separated by exactly one IDLE cycle.
REQ-023 Changes on golden after acceptance SHALL NOT affect the running sweep.
REQ-024 truth_table, mismatch, mismatch_count, first_fail SHALL hold their values after DONE until the next accepted start or reset.
REQ-025 first_fail SHALL read 0 when mismatch_count=0; mismatch distinguishes this from a failure at vector 0.
REQ-026 mismatch_count SHALL saturate naturally at 16 (5 bits sufficient; no overflow).

Reset
REQ-027 reset=0 at a rising CK edge SHALL force IDLE and N=0, busy=0, done=0, truth_table=0, mismatch=0, mismatch_count=0, first_fail=0, counter=0.
REQ-028 Reset mid-sweep SHALL abort it with no done pulse; start sampled in the same cycle as reset=0 SHALL be ignored.

Verification
REQ-029 SETTLE_CYCLES=1, DUT = AND of N bits, golden=16'h8000, start pulse -> done 32 cycles later, truth_table=16'h8000, mismatch=0, mismatch_count=0, first_fail=0.
REQ-030 Same golden, DUT AND with trojan inverting output at N=5 -> truth_table=16'h8020, mismatch=1, mismatch_count=1, first_fail=5.
REQ-031 dut_out tied 1, golden=16'h0000 -> truth_table=16'hFFFF, mismatch_count=16, first_fail=0, mismatch=1.
REQ-032 SETTLE_CYCLES=3 -> N steps 0..15 every 4 cycles, done 64 cycles after start, N=15 during DONE.
REQ-033 reset low 10 cycles into a sweep -> next cycle all outputs 0, state IDLE, no done; re-start completes normally.
REQ-034 start held high continuously, golden toggled mid-sweep -> results match golden latched at start; next sweep begins after one IDLE cycle following done.
